// File: rtl/trng_pkg.sv
// trng_pkg: shared types and default parameters for the ring-oscillator bit collector.
//   trng_state_e        collector FSM state encoding
//   DEF_*               default values for the collector parameters
package trng_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StWarmup  = 3'd1,
        StCollect = 3'd2,
        StHold    = 3'd3,
        StFail    = 3'd4
    } trng_state_e;

    localparam int unsigned DEF_WORD_W     = 64;
    localparam int unsigned DEF_SAMPLE_DIV = 8;
    localparam int unsigned DEF_WARMUP     = 256;
    localparam int unsigned DEF_RCT_CUTOFF = 32;

endpackage

// File: rtl/von_neumann_corrector.sv
// von_neumann_corrector: pairs up incoming bits (a,b); emits a when a != b, nothing when a == b.
//   clk, rst_n   clock, asynchronous active-low reset
//   clr          drops any half-collected pair
//   in_valid     in_bit is a new sample this cycle
//   in_bit       sample value
//   out_valid    out_bit is a debiased bit (same cycle as the second bit of the pair)
//   out_bit      debiased bit (first bit of the pair)
module von_neumann_corrector (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic in_valid,
    input  logic in_bit,
    output logic out_valid,
    output logic out_bit
);

    logic have_a_q;
    logic a_q;

    always_comb begin
        out_valid = in_valid && have_a_q && (a_q != in_bit) && !clr;
        out_bit   = a_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            have_a_q <= 1'b0;
            a_q      <= 1'b0;
        end else if (clr) begin
            have_a_q <= 1'b0;
            a_q      <= 1'b0;
        end else if (in_valid) begin
            if (have_a_q) begin
                have_a_q <= 1'b0;
            end else begin
                have_a_q <= 1'b1;
                a_q      <= in_bit;
            end
        end
    end

endmodule

// File: rtl/trng_bit_collector.sv
// trng_bit_collector: gates the ring oscillator, strobes its sampling flops, runs a
// repetition-count health test on raw bits, optionally von Neumann debiases them and packs
// the result MSB-first into WORD_W-bit words handed out over valid/ready.
//   clk, rst_n    clock, asynchronous active-low reset
//   en            collection enable
//   ro_en         oscillator enable
//   dff_en        one-cycle sample strobe to the source
//   raw_bit       source output, taken the cycle after dff_en
//   word_valid    word_data holds a complete word
//   word_ready    downstream accepts the word
//   word_data     packed entropy word
//   health_fail   sticky repetition-count failure (cleared by en=0)
//   busy          FSM is not idle
// All outputs come straight from flops.
module trng_bit_collector
    import trng_pkg::*;
#(
    parameter int unsigned WORD_W     = DEF_WORD_W,
    parameter int unsigned SAMPLE_DIV = DEF_SAMPLE_DIV,
    parameter int unsigned WARMUP     = DEF_WARMUP,
    parameter int unsigned RCT_CUTOFF = DEF_RCT_CUTOFF,
    parameter bit          VN_EN      = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic              ro_en,
    output logic              dff_en,
    input  logic              raw_bit,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [WORD_W-1:0] word_data,
    output logic              health_fail,
    output logic              busy
);

    localparam int unsigned DIV_W  = $clog2(SAMPLE_DIV);
    localparam int unsigned WARM_W = $clog2(WARMUP + 1);
    localparam int unsigned REP_W  = $clog2(RCT_CUTOFF + 1);
    localparam int unsigned BIT_W  = $clog2(WORD_W + 1);

    trng_state_e       state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [WARM_W-1:0] warm_q, warm_d;
    logic [REP_W-1:0]  rep_q, rep_d, rep_next;
    logic              prev_q, prev_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              sample_pending_q;

    logic ro_en_q, ro_en_d;
    logic dff_en_q, dff_en_d;
    logic word_valid_q, word_valid_d;
    logic health_fail_q, health_fail_d;
    logic busy_q, busy_d;

    logic sample_fire;
    logic xfer;
    logic vn_clr;
    logic vn_valid;
    logic vn_bit;
    logic emit;
    logic emit_bit;

    // A sample is only meaningful while collecting with enable still high.
    assign sample_fire = (state_q == StCollect) && sample_pending_q && en;
    assign xfer        = (state_q == StHold) && word_valid_q && word_ready;
    assign vn_clr      = ((state_q != StCollect) && (state_q != StHold)) || xfer;

    von_neumann_corrector u_vn (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (vn_clr),
        .in_valid  (sample_fire),
        .in_bit    (raw_bit),
        .out_valid (vn_valid),
        .out_bit   (vn_bit)
    );

    always_comb begin
        emit     = sample_fire;
        emit_bit = raw_bit;
        if (VN_EN) begin
            emit     = vn_valid;
            emit_bit = vn_bit;
        end
    end

    // rep_q == 0 means no previous sample, so the next one restarts the run at 1.
    assign rep_next = ((rep_q != '0) && (raw_bit == prev_q)) ? rep_q + REP_W'(1) : REP_W'(1);

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        warm_d    = warm_q;
        rep_d     = rep_q;
        prev_d    = prev_q;
        bit_cnt_d = bit_cnt_q;
        word_d    = word_q;

        unique case (state_q)
            StIdle: begin
                div_d     = '0;
                warm_d    = '0;
                rep_d     = '0;
                bit_cnt_d = '0;
                if (en) begin
                    state_d = StWarmup;
                end
            end
            StWarmup: begin
                div_d     = '0;
                rep_d     = '0;
                bit_cnt_d = '0;
                if (!en) begin
                    state_d = StIdle;
                    warm_d  = '0;
                end else if (warm_q == WARM_W'(WARMUP - 1)) begin
                    state_d = StCollect;
                    warm_d  = '0;
                end else begin
                    warm_d = warm_q + WARM_W'(1);
                end
            end
            StCollect: begin
                if (!en) begin
                    state_d   = StIdle;
                    div_d     = '0;
                    rep_d     = '0;
                    bit_cnt_d = '0;
                end else begin
                    div_d = (div_q == DIV_W'(SAMPLE_DIV - 1)) ? '0 : div_q + DIV_W'(1);
                    if (sample_fire) begin
                        rep_d  = rep_next;
                        prev_d = raw_bit;
                    end
                    if (emit) begin
                        word_d    = {word_q[WORD_W-2:0], emit_bit};
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                    if (sample_fire && (rep_next == REP_W'(RCT_CUTOFF))) begin
                        state_d = StFail;
                    end else if (bit_cnt_q == BIT_W'(WORD_W)) begin
                        state_d = StHold;
                    end
                end
            end
            StHold: begin
                if (xfer) begin
                    bit_cnt_d = '0;
                    state_d   = en ? StCollect : StIdle;
                end
            end
            StFail: begin
                div_d     = '0;
                rep_d     = '0;
                bit_cnt_d = '0;
                if (!en) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are decoded from next-state values so they can be registered without lag.
    always_comb begin
        ro_en_d       = (state_d == StWarmup) || (state_d == StCollect) ||
                        ((state_d == StHold) && en);
        dff_en_d      = (state_d == StCollect) && (div_d == DIV_W'(SAMPLE_DIV - 1));
        word_valid_d  = (state_d == StHold);
        health_fail_d = (state_d == StFail);
        busy_d        = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= StIdle;
            div_q            <= '0;
            warm_q           <= '0;
            rep_q            <= '0;
            prev_q           <= 1'b0;
            bit_cnt_q        <= '0;
            word_q           <= '0;
            sample_pending_q <= 1'b0;
            ro_en_q          <= 1'b0;
            dff_en_q         <= 1'b0;
            word_valid_q     <= 1'b0;
            health_fail_q    <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            div_q            <= div_d;
            warm_q           <= warm_d;
            rep_q            <= rep_d;
            prev_q           <= prev_d;
            bit_cnt_q        <= bit_cnt_d;
            word_q           <= word_d;
            sample_pending_q <= dff_en_q;
            ro_en_q          <= ro_en_d;
            dff_en_q         <= dff_en_d;
            word_valid_q     <= word_valid_d;
            health_fail_q    <= health_fail_d;
            busy_q           <= busy_d;
        end
    end

    assign ro_en       = ro_en_q;
    assign dff_en      = dff_en_q;
    assign word_valid  = word_valid_q;
    assign word_data   = word_q;
    assign health_fail = health_fail_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_trng_bit_collector.sv
// tb_trng_bit_collector: directed, table-driven bench for trng_bit_collector with
// WORD_W=8, SAMPLE_DIV=4, WARMUP=16, RCT_CUTOFF=8. A second instance runs with VN_EN=0.
module tb_trng_bit_collector;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic       en2 = 1'b0;
    logic       raw_bit = 1'b0;
    logic       word_ready = 1'b0;

    logic       ro_en, dff_en, word_valid, health_fail, busy;
    logic [7:0] word_data;
    logic       ro_en2, dff_en2, word_valid2, health_fail2, busy2;
    logic [7:0] word_data2;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic       a;
        logic       b;
        logic [7:0] exp;
    } pair_vec_t;

    typedef struct packed {
        logic       b;
        logic [7:0] exp;
    } bit_vec_t;

    pair_vec_t t2[10];
    pair_vec_t t5[8];
    bit_vec_t  t6[8];

    always #5 clk = ~clk;

    trng_bit_collector #(
        .WORD_W(8), .SAMPLE_DIV(4), .WARMUP(16), .RCT_CUTOFF(8), .VN_EN(1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .ro_en       (ro_en),
        .dff_en      (dff_en),
        .raw_bit     (raw_bit),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .word_data   (word_data),
        .health_fail (health_fail),
        .busy        (busy)
    );

    trng_bit_collector #(
        .WORD_W(8), .SAMPLE_DIV(4), .WARMUP(16), .RCT_CUTOFF(8), .VN_EN(1'b0)
    ) dut_raw (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en2),
        .ro_en       (ro_en2),
        .dff_en      (dff_en2),
        .raw_bit     (raw_bit),
        .word_valid  (word_valid2),
        .word_ready  (word_ready),
        .word_data   (word_data2),
        .health_fail (health_fail2),
        .busy        (busy2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Waits for the strobe of the selected instance, then presents b for the sampling cycle.
    // Returns #1 after the edge on which b was taken.
    task automatic sample(input bit sel, input bit b);
        int t;
        t = 0;
        while (t < 64) begin
            @(negedge clk);
            if ((sel ? dff_en2 : dff_en) === 1'b1) break;
            t++;
        end
        if (t >= 64) begin
            n_vec++;
            n_err++;
            $display("FAIL sample_timeout: no dff_en within 64 cycles (sel=%0d)", sel);
            return;
        end
        raw_bit = b;
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  n;
        bit  bad;

        t2[0] = {1'b1, 1'b0, 8'h01};
        t2[1] = {1'b0, 1'b1, 8'h02};
        t2[2] = {1'b0, 1'b0, 8'h02};
        t2[3] = {1'b1, 1'b0, 8'h05};
        t2[4] = {1'b1, 1'b0, 8'h0B};
        t2[5] = {1'b1, 1'b1, 8'h0B};
        t2[6] = {1'b0, 1'b1, 8'h16};
        t2[7] = {1'b0, 1'b1, 8'h2C};
        t2[8] = {1'b1, 1'b0, 8'h59};
        t2[9] = {1'b0, 1'b1, 8'hB2};

        t5[0] = {1'b1, 1'b0, 8'h81};
        t5[1] = {1'b0, 1'b1, 8'h02};
        t5[2] = {1'b1, 1'b0, 8'h05};
        t5[3] = {1'b0, 1'b1, 8'h0A};
        t5[4] = {1'b1, 1'b0, 8'h15};
        t5[5] = {1'b0, 1'b1, 8'h2A};
        t5[6] = {1'b1, 1'b0, 8'h55};
        t5[7] = {1'b0, 1'b1, 8'hAA};

        t6[0] = {1'b1, 8'h01};
        t6[1] = {1'b1, 8'h03};
        t6[2] = {1'b0, 8'h06};
        t6[3] = {1'b1, 8'h0D};
        t6[4] = {1'b0, 8'h1A};
        t6[5] = {1'b0, 8'h34};
        t6[6] = {1'b1, 8'h69};
        t6[7] = {1'b1, 8'hD3};

        // Reset state.
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_outputs", {ro_en, dff_en, word_valid, health_fail, busy, word_data}, '0);
        check("rst_outputs_raw", {ro_en2, dff_en2, word_valid2, health_fail2, busy2, word_data2},
              '0);

        // 1: asynchronous reset while collecting, then strobe latency from en.
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("collect_ro_en", ro_en, 1'b1);
        check("collect_busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_outputs", {ro_en, dff_en, word_valid, health_fail, busy, word_data}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            n++;
            #1;
            if (dff_en === 1'b1) break;
        end
        check("first_dff_en_latency", n, 20);

        // 2: von Neumann pairs packed MSB-first.
        for (int i = 0; i < 10; i++) begin
            sample(1'b0, t2[i].a);
            sample(1'b0, t2[i].b);
            check($sformatf("vn_word_pair%0d", i), word_data, t2[i].exp);
        end
        check("vn_valid_before_hold", word_valid, 1'b0);
        @(posedge clk);
        #1;
        check("vn_word_valid", word_valid, 1'b1);
        check("vn_word_data", word_data, 8'hB2);

        // 3: backpressure holds the word and stops strobes; one transfer resumes collection.
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (word_data !== 8'hB2 || word_valid !== 1'b1 || dff_en !== 1'b0) bad = 1'b1;
        end
        check("hold_stable", bad, 1'b0);
        word_ready = 1'b1;
        @(posedge clk);
        #1;
        word_ready = 1'b0;
        check("xfer_valid_drop", word_valid, 1'b0);
        check("xfer_busy", busy, 1'b1);
        n = 0;
        while (n < 16 && dff_en !== 1'b1) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("collect_resumed", dff_en, 1'b1);
        en = 1'b0;
        @(posedge clk);
        #1;
        check("idle_after_en_low", busy, 1'b0);

        // 4: stuck-at-1 trips the repetition-count test on the 8th sample.
        @(negedge clk);
        en = 1'b1;
        for (int i = 0; i < 7; i++) sample(1'b0, 1'b1);
        check("rct_7_no_fail", health_fail, 1'b0);
        sample(1'b0, 1'b1);
        check("rct_8_fail", health_fail, 1'b1);
        check("rct_8_ro_en", ro_en, 1'b0);
        check("rct_8_word_valid", word_valid, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("fail_sticky", health_fail, 1'b1);
        en = 1'b0;
        @(posedge clk);
        #1;
        check("fail_cleared", health_fail, 1'b0);
        check("fail_to_idle", busy, 1'b0);

        // 5: partial word discarded on en=0; word_data keeps its bits until overwritten.
        @(negedge clk);
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sample(1'b0, 1'b0);
            sample(1'b0, 1'b1);
        end
        check("partial_word", word_data, 8'h40);
        en = 1'b0;
        @(posedge clk);
        #1;
        check("partial_idle", busy, 1'b0);
        check("partial_word_kept", word_data, 8'h40);
        @(negedge clk);
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sample(1'b0, t5[i].a);
            sample(1'b0, t5[i].b);
            check($sformatf("fresh_word_pair%0d", i), word_data, t5[i].exp);
        end
        @(posedge clk);
        #1;
        check("fresh_word_valid", word_valid, 1'b1);
        en = 1'b0;
        @(posedge clk);
        #1;
        check("hold_en_low_ro_en", ro_en, 1'b0);
        check("hold_en_low_valid", word_valid, 1'b1);
        word_ready = 1'b1;
        @(posedge clk);
        #1;
        word_ready = 1'b0;
        check("hold_en_low_xfer_idle", {busy, word_valid}, 2'b00);

        // 6: raw bits packed directly when the corrector is disabled.
        @(negedge clk);
        en2 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sample(1'b1, t6[i].b);
            check($sformatf("raw_word_bit%0d", i), word_data2, t6[i].exp);
        end
        @(posedge clk);
        #1;
        check("raw_word_valid", word_valid2, 1'b1);
        check("raw_word_data", word_data2, 8'hD3);
        check("vn_dut_quiet", busy, 1'b0);
        en2 = 1'b0;
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
